// File: rtl/lcd_rx_checker.sv
// DE-mode RGB panel receiver: oversamples the pixel clock on clk, recovers pixel
// coordinates, checks line/frame geometry and accumulates a per-frame checksum.
module lcd_rx_checker #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int VBLANK_MIN = 64,
  parameter int XW         = 9
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lcd_clk,
  input  logic          lcd_de,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  output logic          pix_valid,
  output logic [XW-1:0] pix_x,
  output logic [XW-1:0] pix_y,
  output logic [23:0]   pix_rgb,
  output logic          frame_done,
  output logic [23:0]   frame_checksum,
  output logic [15:0]   frame_count,
  output logic          line_err,
  output logic          frame_err,
  output logic          synced
);

  localparam int XCW = $clog2(H_ACTIVE + 1);
  localparam int YCW = $clog2(V_ACTIVE + 1);
  localparam int GW  = $clog2(VBLANK_MIN + 1);

  localparam logic [XCW-1:0] H_MAX  = XCW'(H_ACTIVE);
  localparam logic [YCW-1:0] V_LAST = YCW'(V_ACTIVE - 1);
  localparam logic [GW-1:0]  G_MAX  = GW'(VBLANK_MIN);
  localparam logic [GW-1:0]  G_HIT  = GW'(VBLANK_MIN - 1);

  typedef enum logic [1:0] {SYNC, WAIT_LINE, LINE} state_e;

  // Input capture and tick stage
  logic        s1_clk_q, s2_clk_q, s1_de_q;
  logic [23:0] s1_rgb_q;
  logic        tick_q, tde_q;
  logic [23:0] trgb_q;

  // Core state
  state_e           state_q, state_d;
  logic [XCW-1:0]   x_q, x_d;
  logic [YCW-1:0]   y_q, y_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [23:0]      acc_q, acc_d;
  logic             pix_valid_q, pix_valid_d;
  logic [XW-1:0]    pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [23:0]      pix_rgb_q, pix_rgb_d;
  logic             frame_done_q, frame_done_d;
  logic [23:0]      checksum_q, checksum_d;
  logic [15:0]      count_q, count_d;
  logic             line_err_q, line_err_d;
  logic             frame_err_q, frame_err_d;
  logic             synced_q, synced_d;
  logic             gap_hit;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_clk_q <= 1'b0;
      s2_clk_q <= 1'b0;
      s1_de_q  <= 1'b0;
      s1_rgb_q <= '0;
      tick_q   <= 1'b0;
      tde_q    <= 1'b0;
      trgb_q   <= '0;
    end else begin
      s1_clk_q <= lcd_clk;
      s2_clk_q <= s1_clk_q;
      s1_de_q  <= lcd_de;
      s1_rgb_q <= {red, green, blue};
      tick_q   <= s1_clk_q & ~s2_clk_q;
      tde_q    <= s1_de_q;
      trgb_q   <= s1_rgb_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= SYNC;
      x_q          <= '0;
      y_q          <= '0;
      gap_q        <= '0;
      acc_q        <= '0;
      pix_valid_q  <= 1'b0;
      pix_x_q      <= '0;
      pix_y_q      <= '0;
      pix_rgb_q    <= '0;
      frame_done_q <= 1'b0;
      checksum_q   <= '0;
      count_q      <= '0;
      line_err_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      synced_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      gap_q        <= gap_d;
      acc_q        <= acc_d;
      pix_valid_q  <= pix_valid_d;
      pix_x_q      <= pix_x_d;
      pix_y_q      <= pix_y_d;
      pix_rgb_q    <= pix_rgb_d;
      frame_done_q <= frame_done_d;
      checksum_q   <= checksum_d;
      count_q      <= count_d;
      line_err_q   <= line_err_d;
      frame_err_q  <= frame_err_d;
      synced_q     <= synced_d;
    end
  end

  // Fires once per DE-low run, on the tick that takes the gap counter to VBLANK_MIN.
  assign gap_hit = tick_q & ~tde_q & (gap_q == G_HIT);

  // NOTE: every signal written here gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    gap_d        = gap_q;
    acc_d        = acc_q;
    pix_valid_d  = 1'b0;
    pix_x_d      = pix_x_q;
    pix_y_d      = pix_y_q;
    pix_rgb_d    = pix_rgb_q;
    frame_done_d = 1'b0;
    checksum_d   = checksum_q;
    count_d      = count_q;
    line_err_d   = line_err_q;
    frame_err_d  = frame_err_q;
    synced_d     = synced_q;

    if (tick_q) begin
      if (tde_q)               gap_d = '0;
      else if (gap_q != G_MAX) gap_d = gap_q + 1'b1;
    end

    unique case (state_q)
      SYNC: begin
        if (gap_hit) begin
          state_d  = WAIT_LINE;
          synced_d = 1'b1;
          y_d      = '0;
        end
      end
      WAIT_LINE: begin
        if (tick_q && tde_q) begin
          pix_valid_d = 1'b1;
          pix_x_d     = '0;
          pix_y_d     = XW'(y_q);
          pix_rgb_d   = trgb_q;
          acc_d       = acc_q + trgb_q;
          x_d         = XCW'(1);
          state_d     = LINE;
        end else if (gap_hit && y_q != '0) begin
          // Vertical blank inside a frame: abandon the partial frame.
          frame_err_d = 1'b1;
          y_d         = '0;
          acc_d       = '0;
        end
      end
      LINE: begin
        if (tick_q && tde_q) begin
          if (x_q < H_MAX) begin
            pix_valid_d = 1'b1;
            pix_x_d     = XW'(x_q);
            pix_y_d     = XW'(y_q);
            pix_rgb_d   = trgb_q;
            acc_d       = acc_q + trgb_q;
            x_d         = x_q + 1'b1;
          end else begin
            line_err_d = 1'b1;
          end
        end else if (tick_q) begin
          if (x_q != H_MAX) line_err_d = 1'b1;
          x_d     = '0;
          state_d = WAIT_LINE;
          if (y_q == V_LAST) begin
            frame_done_d = 1'b1;
            checksum_d   = acc_d;
            acc_d        = '0;
            count_d      = count_q + 1'b1;
            y_d          = '0;
          end else begin
            y_d = y_q + 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  assign pix_valid      = pix_valid_q;
  assign pix_x          = pix_x_q;
  assign pix_y          = pix_y_q;
  assign pix_rgb        = pix_rgb_q;
  assign frame_done     = frame_done_q;
  assign frame_checksum = checksum_q;
  assign frame_count    = count_q;
  assign line_err       = line_err_q;
  assign frame_err      = frame_err_q;
  assign synced         = synced_q;

endmodule

// File: tb/tb_lcd_rx_checker.sv
// Directed bench for lcd_rx_checker with a small 4x3 panel geometry; captured
// pixels and frame strobes are compared against hand-computed expectations.
module tb_lcd_rx_checker;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int VB = 8;
  localparam int XW = 9;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [XW-1:0] y;
    logic [23:0]   rgb;
  } pix_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lcd_clk = 1'b0;
  logic          lcd_de = 1'b0;
  logic [7:0]    red = '0, green = '0, blue = '0;
  logic          pix_valid;
  logic [XW-1:0] pix_x, pix_y;
  logic [23:0]   pix_rgb;
  logic          frame_done;
  logic [23:0]   frame_checksum;
  logic [15:0]   frame_count;
  logic          line_err, frame_err, synced;

  int   n_vec = 0;
  int   n_err = 0;
  int   fd_cnt = 0;
  pix_t got_q[$];
  pix_t exp_q[$];

  lcd_rx_checker #(.H_ACTIVE(H), .V_ACTIVE(V), .VBLANK_MIN(VB), .XW(XW)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_clk(lcd_clk), .lcd_de(lcd_de),
    .red(red), .green(green), .blue(blue),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_done(frame_done), .frame_checksum(frame_checksum),
    .frame_count(frame_count), .line_err(line_err), .frame_err(frame_err),
    .synced(synced)
  );

  always #5 clk = ~clk;

  // Monitor samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      got_q.delete();
      fd_cnt = 0;
    end else begin
      if (pix_valid) got_q.push_back('{x: pix_x, y: pix_y, rgb: pix_rgb});
      if (frame_done) fd_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One pixel-clock period: high 2 clk cycles, low 2 clk cycles. Called on a negedge.
  task automatic ptick(input logic de, input logic [23:0] rgb);
    lcd_de = de;
    {red, green, blue} = rgb;
    lcd_clk = 1'b1;
    repeat (2) @(negedge clk);
    lcd_clk = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++) ptick(1'b0, 24'h0);
  endtask

  // n DE-high pixels with rgb = base, base+1, ... then one DE-low tick.
  task automatic send_line(input int n, input logic [23:0] base);
    for (int i = 0; i < n; i++) ptick(1'b1, base + 24'(i));
    ptick(1'b0, 24'h0);
  endtask

  task automatic expect_line(input int n, input int y, input logic [23:0] base);
    for (int i = 0; i < n; i++)
      exp_q.push_back('{x: XW'(i), y: XW'(y), rgb: base + 24'(i)});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n   = 1'b0;
    lcd_clk = 1'b0;
    lcd_de  = 1'b0;
    {red, green, blue} = 24'h0;
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_pixels(input string tag);
    check({tag, "_npix"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check({tag, "_x"},   32'(got_q[i].x),   32'(exp_q[i].x));
        check({tag, "_y"},   32'(got_q[i].y),   32'(exp_q[i].y));
        check({tag, "_rgb"}, 32'(got_q[i].rgb), 32'(exp_q[i].rgb));
      end
    end
  endtask

  initial begin
    // Reset state and pixels before sync, then a clean frame.
    do_reset();
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_synced", 32'(synced), 0);
    check("rst_count", 32'(frame_count), 0);
    check("rst_checksum", 32'(frame_checksum), 0);
    check("rst_errs", {30'd0, line_err, frame_err}, 0);
    for (int i = 0; i < 3; i++) ptick(1'b1, 24'h55);
    check("presync_npix", got_q.size(), 0);
    check("presync_synced", 32'(synced), 0);
    blank(VB);
    check("sync_synced", 32'(synced), 1);
    for (int l = 0; l < V; l++) begin
      send_line(H, 24'(1 + 4 * l));
      expect_line(H, l, 24'(1 + 4 * l));
    end
    repeat (3) @(negedge clk);
    check_pixels("clean");
    check("clean_fd", fd_cnt, 1);
    check("clean_sum", 32'(frame_checksum), 32'h4E);
    check("clean_count", 32'(frame_count), 1);
    check("clean_errs", {30'd0, line_err, frame_err}, 0);

    // Long line: two extra pixels on line 1 are dropped.
    do_reset();
    blank(VB);
    send_line(H, 24'd1);
    send_line(6, 24'd5);
    send_line(H, 24'd9);
    for (int l = 0; l < V; l++) expect_line(H, l, 24'(1 + 4 * l));
    repeat (3) @(negedge clk);
    check_pixels("long");
    check("long_line_err", 32'(line_err), 1);
    check("long_fd", fd_cnt, 1);
    check("long_sum", 32'(frame_checksum), 32'h4E);
    check("long_frame_err", 32'(frame_err), 0);

    // Short line: line 0 has only 3 pixels but still counts.
    do_reset();
    blank(VB);
    send_line(3, 24'd1);
    expect_line(3, 0, 24'd1);
    send_line(H, 24'd4);
    expect_line(H, 1, 24'd4);
    repeat (3) @(negedge clk);
    check("short_fd_early", fd_cnt, 0);
    check("short_line_err", 32'(line_err), 1);
    send_line(H, 24'd8);
    expect_line(H, 2, 24'd8);
    repeat (3) @(negedge clk);
    check_pixels("short");
    check("short_fd", fd_cnt, 1);
    check("short_sum", 32'(frame_checksum), 32'h42);

    // Early vblank after two lines, then a clean frame.
    do_reset();
    blank(VB);
    send_line(H, 24'h100);
    expect_line(H, 0, 24'h100);
    send_line(H, 24'h104);
    expect_line(H, 1, 24'h104);
    blank(VB);
    repeat (3) @(negedge clk);
    check("early_frame_err", 32'(frame_err), 1);
    check("early_fd", fd_cnt, 0);
    check("early_count", 32'(frame_count), 0);
    for (int l = 0; l < V; l++) begin
      send_line(H, 24'(1 + 4 * l));
      expect_line(H, l, 24'(1 + 4 * l));
    end
    repeat (3) @(negedge clk);
    check_pixels("early");
    check("early_fd_after", fd_cnt, 1);
    check("early_sum", 32'(frame_checksum), 32'h4E);
    check("early_line_err", 32'(line_err), 0);

    // Checksum wrap, then asynchronous reset mid-line.
    do_reset();
    blank(VB);
    for (int l = 0; l < V; l++) begin
      for (int i = 0; i < H; i++) ptick(1'b1, 24'hFFFFFF);
      ptick(1'b0, 24'h0);
    end
    repeat (3) @(negedge clk);
    check("wrap_fd", fd_cnt, 1);
    check("wrap_sum", 32'(frame_checksum), 32'hFFFFF4);
    check("wrap_count", 32'(frame_count), 1);
    ptick(1'b1, 24'h123456);
    ptick(1'b1, 24'h123457);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", 32'(frame_checksum), 0);
    check("mid_rst_count", 32'(frame_count), 0);
    check("mid_rst_synced", 32'(synced), 0);
    check("mid_rst_pix", {7'd0, pix_valid, pix_x, pix_y, 6'd0}, 0);
    check("mid_rst_rgb", 32'(pix_rgb), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send_line(H, 24'd1);
    repeat (3) @(negedge clk);
    check("nosync_npix", got_q.size(), 0);
    check("nosync_synced", 32'(synced), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
